// File: rtl/rtc_write_sequencer_if.sv
// Four-phase register-write bus between the RTC write sequencer (master)
// and the RTC bus driver (slave).
interface rtc_write_sequencer_if;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;

  modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
  modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/rtc_write_sequencer.sv
// Latches edited date/time/timer fields on start and writes them to the RTC
// one register at a time over a req/ack handshake. RTC_WR_CMD_EN wraps the field
// writes in command-register pre/post writes.
module rtc_write_sequencer #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [7:0]  CMD_ADDR = 8'hF0,
  parameter logic [7:0]  CMD_PRE  = 8'h10,
  parameter logic [7:0]  CMD_POST = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [7:0]            i_d_in,
  input  logic [7:0]            i_me_in,
  input  logic [7:0]            i_a_in,
  input  logic [7:0]            i_h_in,
  input  logic                  i_pm_in,
  input  logic [7:0]            i_m_in,
  input  logic [7:0]            i_s_in,
  input  logic [7:0]            i_ht_in,
  input  logic [7:0]            i_mt_in,
  input  logic [7:0]            i_st_in,
  rtc_write_sequencer_if.master bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

`ifdef RTC_WR_CMD_EN
  localparam int unsigned N_ITEMS = 11;
`else
  localparam int unsigned N_ITEMS = 9;
`endif
  localparam int unsigned IW = 4;
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_REL} state_t;

  // Hour is held already packed as {pm, hour[6:0]}.
  typedef struct packed {
    logic [7:0] s, m, h, d, me, a, st, mt, ht;
  } fields_t;

  function automatic logic [7:0] c59(input logic [7:0] x);
    if (x[7:4] > 4'd5 || x[3:0] > 4'd9) return 8'h00;
    return {4'd5 - x[7:4], 4'd9 - x[3:0]};
  endfunction

  function automatic logic [7:0] c23(input logic [7:0] x);
    if (x > 8'h23 || x[3:0] > 4'd9) return 8'h00;
    if (x[3:0] <= 4'd3) return {4'd2 - x[7:4], 4'd3 - x[3:0]};
    return {4'd1 - x[7:4], 4'd13 - x[3:0]};
  endfunction

  // Returns {address, data} for sequence position idx.
  function automatic logic [15:0] item(input logic [IW-1:0] idx, input fields_t f);
    logic [IW-1:0] fi;
`ifdef RTC_WR_CMD_EN
    if (idx == 4'd0) return {CMD_ADDR, CMD_PRE};
    if (idx == IW'(N_ITEMS - 1)) return {CMD_ADDR, CMD_POST};
    fi = idx - 4'd1;
`else
    fi = idx;
`endif
    case (fi)
      4'd0:    return {8'h21, f.s};
      4'd1:    return {8'h22, f.m};
      4'd2:    return {8'h23, f.h};
      4'd3:    return {8'h24, f.d};
      4'd4:    return {8'h25, f.me};
      4'd5:    return {8'h26, f.a};
      4'd6:    return {8'h41, c59(f.st)};
      4'd7:    return {8'h42, c59(f.mt)};
      default: return {8'h43, c23(f.ht)};
    endcase
  endfunction

  state_t        r_state, w_state;
  logic [IW-1:0] r_idx, w_idx, w_idx_inc;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_req, w_req, r_busy, w_busy, r_done, w_done, r_err, w_err;
  logic [7:0]    r_addr, w_addr, r_data, w_data;
  fields_t       r_shadow, w_live;
  logic          w_load, w_timeout;
  logic          w_unused_bits;

  assign w_live        = {i_s_in, i_m_in, {i_pm_in, i_h_in[6:0]}, i_d_in, i_me_in,
                          i_a_in, i_st_in, i_mt_in, i_ht_in};
  assign w_idx_inc     = r_idx + 4'd1;
  assign w_timeout     = (r_cnt == CW'(TIMEOUT - 1));
  assign w_unused_bits = ^{i_h_in[7], CMD_ADDR, CMD_PRE, CMD_POST};

  // NOTE: every next-state value gets a default before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state = r_state;
    w_idx   = r_idx;
    w_cnt   = r_cnt + CW'(1);
    w_req   = r_req;
    w_addr  = r_addr;
    w_data  = r_data;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_err   = 1'b0;
    w_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt = '0;
        if (i_start) begin
          w_state          = S_REQ;
          w_idx            = '0;
          {w_addr, w_data} = item('0, w_live);
          w_req            = 1'b1;
          w_busy           = 1'b1;
          w_load           = 1'b1;
        end
      end
      S_REQ: begin
        if (bus.wr_ack) begin
          w_state = S_REL;
          w_req   = 1'b0;
          w_cnt   = '0;
        end else if (w_timeout) begin
          w_state = S_IDLE;
          w_req   = 1'b0;
          w_busy  = 1'b0;
          w_err   = 1'b1;
          w_cnt   = '0;
        end
      end
      S_REL: begin
        if (!bus.wr_ack) begin
          w_cnt = '0;
          if (r_idx == IW'(N_ITEMS - 1)) begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end else begin
            w_state          = S_REQ;
            w_idx            = w_idx_inc;
            {w_addr, w_data} = item(w_idx_inc, r_shadow);
            w_req            = 1'b1;
          end
        end else if (w_timeout) begin
          w_state = S_IDLE;
          w_busy  = 1'b0;
          w_err   = 1'b1;
          w_cnt   = '0;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_addr  <= 8'h00;
      r_data  <= 8'h00;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_cnt   <= w_cnt;
      r_req   <= w_req;
      r_addr  <= w_addr;
      r_data  <= w_data;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  // NOTE: the shadow fields carry no reset; they are only read after a start has loaded them.
  always_ff @(posedge clk) begin
    if (w_load) r_shadow <= w_live;
  end

  assign bus.wr_req  = r_req;
  assign bus.wr_addr = r_addr;
  assign bus.wr_data = r_data;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule

// File: doc/rtc_write_sequencer.md
# rtc_write_sequencer

Write-back engine for the RTC path. It latches the edited BCD date, time and countdown-timer fields, plus the PM flag, when `start` is pulsed. It packs them into the RTC register format that the display mux decodes: hour bit 7 is the PM flag, and timer fields are stored as BCD complements against 23/59/59. It then issues one register write per field over a four-phase req/ack handshake to the RTC bus driver. It sits between the user edit logic and the RTC interface driver, as the write counterpart of the display data path.

## Interface
- `TIMEOUT`, 255: maximum cycles to wait on any single `wr_ack` edge before aborting.
- `CMD_ADDR`, 8'hF0: command register address, used only under `RTC_WR_CMD_EN`.
- `CMD_PRE`, 8'h10: data written to `CMD_ADDR` before the field writes.
- `CMD_POST`, 8'h00: data written to `CMD_ADDR` after the field writes.
- `clk` in 1: system clock; single clock domain.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to begin a write sequence.
- `d_in`, `me_in`, `a_in` in 8 each: day, month, year, in BCD.
- `h_in` in 8: hour in BCD, 01–12; bit 7 is ignored.
- `pm_in` in 1: 1 means PM.
- `m_in`, `s_in` in 8 each: minute and second, in BCD.
- `ht_in`, `mt_in`, `st_in` in 8 each: timer hours/minutes/seconds as displayed, in BCD.
- `wr_req` out 1: write request.
- `wr_addr` out 8: register address; stable while `wr_req` is 1.
- `wr_data` out 8: register data; stable while `wr_req` is 1.
- `wr_ack` in 1: acknowledge from the bus driver.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle pulse on successful completion.
- `err` out 1: one-cycle pulse on timeout abort.

## Operation
- States:
  - IDLE
  - REQ: `wr_req`=1, waiting for `wr_ack`=1.
  - REL: `wr_req`=0, waiting for `wr_ack`=0.
- Transitions:
  - IDLE→REQ on `start`. All inputs are latched into shadow registers on that edge; index is set to 0.
  - REQ→REL when `wr_ack` is sampled 1.
  - REL→REQ when `wr_ack` is sampled 0 and the index is not the last; the index increments.
  - REL→IDLE when `wr_ack` is sampled 0 on the last index; `done` pulses.
- Write order (index 0..8), each item written as address←data:
  - 8'h21←sec
  - 8'h22←min
  - 8'h23←{`pm_in`, `h_in[6:0]`}
  - 8'h24←day
  - 8'h25←month
  - 8'h26←year
  - 8'h41←C59(st)
  - 8'h42←C59(mt)
  - 8'h43←C23(ht)
- C59(x), digit-wise BCD complement: tens = 5−x[7:4], units = 9−x[3:0].
- C23(x):
  - If x[3:0] ≤ 3: tens = 2−x[7:4], units = 3−x[3:0].
  - Otherwise: tens = 1−x[7:4], units = 13−x[3:0].
- Out-of-range or non-BCD input writes 8'h00:
  - C59: x > 8'h59, or any digit > 9.
  - C23: x > 8'h23, or any digit > 9.
- `start` while `busy` is ignored; shadow registers do not change.
- Input changes after latch have no effect on the sequence in progress.
- Timeout:
  - A cycle counter clears on each state entry and counts while in REQ or REL.
  - When the count reaches `TIMEOUT`: `wr_req`←0, `err` pulses, `busy`←0, return to IDLE. `done` is not asserted.
- `reset` at any point, including mid-handshake, forces IDLE on the next edge. An in-flight write is abandoned.

## Timing
- All outputs are registered. Reset values:
  - `wr_req`=0, `busy`=0, `done`=0, `err`=0
  - `wr_addr`=8'h00, `wr_data`=8'h00
  - state=IDLE, index=0, counter=0
- Start latency: `start` sampled at edge N → at edge N `busy`=1, `wr_req`=1, `wr_addr`/`wr_data` = item 0.
- `wr_ack` sampled 1 at edge M → `wr_req`=0 at edge M. Address and data hold until the next item loads.
- `wr_ack` sampled 0 at edge K in REL → next item and `wr_req`=1 at edge K. With a responder that acks in 1 cycle and releases in 1 cycle, this gives 2 cycles per write.
- Last release:
  - `done`=1 for exactly one cycle.
  - `busy`=0 at the same edge.
  - `start` is accepted again in the following cycle.
- Nine writes complete in 18 cycles minimum (22 with `RTC_WR_CMD_EN`).

## Configuration
- `RTC_WR_CMD_EN` defined:
  - Sequence becomes 11 items (index 0..10).
  - Index 0 is `CMD_ADDR`←`CMD_PRE`.
  - Indices 1..9 are the field writes.
  - Index 10 is `CMD_ADDR`←`CMD_POST`.
- `RTC_WR_CMD_EN` undefined: exactly the 9 field writes; `CMD_*` parameters are unused.

## Test plan
- Reset then idle, `start`=0 → all outputs 0 indefinitely.
- Inputs s=8'h45, m=8'h30, h=8'h11, `pm_in`=1, d=8'h15, me=8'h06, a=8'h16; st=8'h10, mt=8'h05, ht=8'h04; 1-cycle ack responder. Required:
  - Writes 21←45, 22←30, 23←91, 24←15, 25←06, 26←16, 41←49, 42←54, 43←19.
  - `done` pulses at cycle 18 after `start`.
- ht=8'h23, mt=8'h59, st=8'h00 → 43←00, 42←00, 41←59. ht=8'h24 → 43←00.
- Inputs changed and `start` re-pulsed during write 3 → sequence data unchanged; no restart.
- `wr_ack` held 0 → `err` pulses `TIMEOUT` cycles after `wr_req` rises; `wr_req`=0, `busy`=0, no `done`.
- `reset` asserted while `wr_req`=1 at item 4 → IDLE next edge, `wr_req`=0. With `RTC_WR_CMD_EN`, a full run shows F0←10 first and F0←00 last.
